// File: rtl/seq_detector_param_if.sv
// Bundle of the serial sample stream, configuration and match outputs of seq_detector_param.
// The master drives the stream and configuration; the slave (the detector) returns the match signals.
interface seq_detector_param_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 16
);
  // Handshake: en is a valid with no ready; the detector consumes x on every rising edge where
  // en=1 and cfg_load=0, so the producer must hold a bit only for the single cycle it is valid.
  logic             en;
  logic             x;
  logic             cfg_load;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic             overlap_en;
  logic             cnt_clr;
  logic             z;
  logic             z_q;
  logic             armed;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output en, x, cfg_load, pattern, pat_len, overlap_en, cnt_clr,
    input  z, z_q, armed, match_cnt
  );

  modport slave (
    input  en, x, cfg_load, pattern, pat_len, overlap_en, cnt_clr,
    output z, z_q, armed, match_cnt
  );
endinterface

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector: Mealy match z, registered z_q and a saturating
// match counter. The pattern's bit [len-1] is the oldest bit received, bit [0] the newest.
module seq_detector_param #(
  parameter int               PAT_W   = 8,
  parameter int               LEN_W   = 4,
  parameter int               CNT_W   = 16,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(8'b0000_1010),
  parameter int               DEF_LEN = 4,
  parameter bit               DEF_OVL = 1'b0
) (
  input logic                clk,
  input logic                rst,
  seq_detector_param_if.slave bus
);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

  logic [PAT_W-1:0] cfg_pat;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_ovl;
  logic [PAT_W-2:0] hist;
  logic [LEN_W-1:0] bit_cnt;
  logic             z_q;
  logic [CNT_W-1:0] match_cnt;

  logic [LEN_W-1:0] eff_len;
  logic [LEN_W-1:0] len_m1;
  logic             len_nz;
  logic [PAT_W-1:0] cand;
  logic [PAT_W-1:0] mask;
  logic             hit;
  logic             armed;
  logic             z;

  // Only the low eff_len bits of the candidate window take part in the compare.
  always_comb begin
    eff_len = (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
    len_nz  = (eff_len != '0);
    len_m1  = eff_len - LEN_W'(1);
    cand    = {hist, bus.x};
    mask    = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < eff_len);
    end
    hit   = (((cand ^ cfg_pat) & mask) == '0);
    armed = len_nz && (bit_cnt >= len_m1);
    z     = bus.en && armed && hit && !bus.cfg_load && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_pat   <= DEF_PAT;
      cfg_len   <= LEN_W'(DEF_LEN);
      cfg_ovl   <= DEF_OVL;
      hist      <= '0;
      bit_cnt   <= '0;
      z_q       <= 1'b0;
      match_cnt <= '0;
    end else begin
      z_q <= z;

      if (bus.cnt_clr) begin
        match_cnt <= '0;
      end else if (z && (match_cnt != '1)) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end

      if (bus.cfg_load) begin
        cfg_pat <= bus.pattern;
        cfg_len <= bus.pat_len;
        cfg_ovl <= bus.overlap_en;
        hist    <= '0;
        bit_cnt <= '0;
      end else if (bus.en) begin
        hist <= cand[PAT_W-2:0];
        // A non-overlapping match consumes the window, so the next one needs L fresh bits.
        if (z && !cfg_ovl) begin
          bit_cnt <= '0;
        end else if (len_nz && (bit_cnt < len_m1)) begin
          bit_cnt <= bit_cnt + LEN_W'(1);
        end
      end
    end
  end

  assign bus.z         = z;
  assign bus.z_q       = z_q;
  assign bus.armed     = armed;
  assign bus.match_cnt = match_cnt;
endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed vector table, hand-written corner sequences and
// random stimulus, all checked against a queue-based reference model of the matching rules.
module tb_seq_detector_param;
  localparam int PAT_W = 8;
  localparam int LEN_W = 4;

  logic clk;
  logic rst;

  seq_detector_param_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(16)) bus  ();
  seq_detector_param_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(2))  bus2 ();

  seq_detector_param #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  seq_detector_param #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .bus(bus2.slave)
  );

  // second instance sees the same stream; it only differs in counter width
  assign bus2.en         = bus.en;
  assign bus2.x          = bus.x;
  assign bus2.cfg_load   = bus.cfg_load;
  assign bus2.pattern    = bus.pattern;
  assign bus2.pat_len    = bus.pat_len;
  assign bus2.overlap_en = bus.overlap_en;
  assign bus2.cnt_clr    = bus.cnt_clr;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_q[$];     // enabled bits since last restart, newest at back
  int         m_fresh;    // bits usable for the next match
  longint     m_cnt;      // unsaturated match count
  bit         m_zq;
  bit         m_z;
  bit         m_armed;

  function automatic int eff_l();
    return (m_len > PAT_W) ? PAT_W : m_len;
  endfunction

  task automatic model_reset();
    m_pat   = 8'b0000_1010;
    m_len   = 4;
    m_ovl   = 1'b0;
    m_q.delete();
    m_fresh = 0;
    m_cnt   = 0;
    m_zq    = 1'b0;
  endtask

  task automatic model_check();
    int L;
    bit ok;
    L       = eff_l();
    m_armed = (L >= 1) && (m_fresh >= L - 1);
    m_z     = 1'b0;
    if (bus.en && !bus.cfg_load && !rst && m_armed) begin
      ok = 1'b1;
      for (int k = 0; k < L; k++) begin
        bit b;
        b = (k == 0) ? bus.x : m_q[m_q.size() - k];
        if (b != m_pat[k]) ok = 1'b0;
      end
      m_z = ok;
    end
    chk("z", bus.z, m_z);
    chk("armed", bus.armed, m_armed);
    chk("z_q", bus.z_q, m_zq);
    chk("cnt16", bus.match_cnt, (m_cnt > 65535) ? 65535 : m_cnt);
    chk("cnt2", bus2.match_cnt, (m_cnt > 3) ? 3 : m_cnt);
  endtask

  task automatic model_update();
    if (rst) begin
      model_reset();
    end else begin
      m_zq = m_z;
      if (bus.cnt_clr) m_cnt = 0;
      else if (m_z) m_cnt++;
      if (bus.cfg_load) begin
        m_pat   = bus.pattern;
        m_len   = int'(bus.pat_len);
        m_ovl   = bus.overlap_en;
        m_q.delete();
        m_fresh = 0;
      end else if (bus.en) begin
        m_q.push_back(bus.x);
        if (m_q.size() > PAT_W) void'(m_q.pop_front());
        if (m_z && !m_ovl) m_fresh = 0;
        else if (m_fresh < 1000) m_fresh++;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit r, input bit en, input bit x, input bit ld,
                       input logic [7:0] pat, input logic [3:0] len, input bit ovl, input bit clr);
    @(negedge clk);
    rst            = r;
    bus.en         = en;
    bus.x          = x;
    bus.cfg_load   = ld;
    bus.pattern    = pat;
    bus.pat_len    = len;
    bus.overlap_en = ovl;
    bus.cnt_clr    = clr;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         en;
    bit         x;
    bit         ld;
    logic [7:0] pat;
    logic [3:0] len;
    bit         ovl;
    bit         ez;
    int         ea;   // expected armed, -1 = not checked
  } vec_t;

  vec_t vecs[$];

  task automatic add_bit(input bit x, input bit ez, input int ea);
    vecs.push_back('{1'b1, x, 1'b0, 8'h00, 4'h0, 1'b0, ez, ea});
  endtask
  task automatic add_idle(input int ea);
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, ea});
  endtask
  task automatic add_load(input bit en, input bit x, input logic [7:0] pat,
                          input logic [3:0] len, input bit ovl, input int ea);
    vecs.push_back('{en, x, 1'b1, pat, len, ovl, 1'b0, ea});
  endtask
  // bits sent MSB first; match expected only at position mpos (1-based), armed from afrom on
  task automatic add_stream(input logic [15:0] bits, input int n, input int mpos, input int afrom);
    for (int i = 0; i < n; i++) add_bit(bits[n-1-i], (i + 1 == mpos), (i + 1 >= afrom) ? 1 : 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0; bus.x = 1'b0; bus.cfg_load = 1'b0; bus.pattern = '0;
    bus.pat_len = '0; bus.overlap_en = 1'b0; bus.cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    model_reset();

    // defaults 1010 / len 4 / non-overlapping
    add_bit(1, 0, 0); add_bit(0, 0, 0); add_bit(1, 0, 0);
    add_bit(0, 1, 1); add_bit(1, 0, 0); add_bit(0, 0, 0);
    // overlapping 1010
    add_load(0, 0, 8'b0000_1010, 4'd4, 1, 0);
    add_bit(1, 0, 0); add_bit(0, 0, 0); add_bit(1, 0, 0);
    add_bit(0, 1, 1); add_bit(1, 0, 1); add_bit(0, 1, 1);
    // full-width pattern, then again with en gaps
    add_load(0, 0, 8'b1101_0011, 4'd8, 1, 1);
    add_stream(16'b1101_0011_0101_0011, 16, 8, 8);
    add_stream(16'h00d3, 8, 8, 1);
    add_bit(1, 0, 1); add_idle(1); add_bit(1, 0, 1); add_bit(0, 0, 1); add_idle(1); add_idle(1);
    add_bit(1, 0, 1); add_bit(0, 0, 1); add_bit(0, 0, 1); add_idle(1); add_bit(1, 0, 1);
    add_bit(1, 1, 1);
    // 111 overlapping vs non-overlapping
    add_load(0, 0, 8'b0000_0111, 4'd3, 1, 1);
    add_stream(16'h001f, 5, 0, 3);
    vecs[vecs.size()-1].ez = 1; vecs[vecs.size()-2].ez = 1; vecs[vecs.size()-3].ez = 1;
    add_load(0, 0, 8'b0000_0111, 4'd3, 0, 1);
    add_bit(1, 0, 0); add_bit(1, 0, 0); add_bit(1, 1, 1); add_bit(1, 0, 0); add_bit(1, 0, 0);
    // load on a completing bit discards it
    add_load(1, 1, 8'b0000_0111, 4'd3, 0, 1);
    add_bit(1, 0, 0); add_bit(1, 0, 0); add_bit(1, 1, 1);
    // zero length never matches; oversize length clamps to PAT_W
    add_load(0, 0, 8'b0000_0111, 4'd0, 1, 0);
    add_bit(1, 0, 0); add_bit(1, 0, 0); add_bit(1, 0, 0); add_bit(1, 0, 0);
    add_load(0, 0, 8'b1101_0011, 4'd15, 0, 0);
    add_stream(16'h00d3, 8, 8, 8);

    foreach (vecs[i]) begin
      drive(0, vecs[i].en, vecs[i].x, vecs[i].ld, vecs[i].pat, vecs[i].len, vecs[i].ovl, 0);
      chk($sformatf("tbl_z[%0d]", i), bus.z, vecs[i].ez);
      if (vecs[i].ea >= 0) chk($sformatf("tbl_armed[%0d]", i), bus.armed, vecs[i].ea);
      tick();
    end

    // reset mid-sequence: history and configuration return to defaults
    drive(0, 0, 0, 1, 8'b0000_0101, 4'd4, 1, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 1, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    chk("rst_mid_z", bus.z, 0);
    chk("rst_cnt", bus.match_cnt, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 1, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    chk("rst_default_z", bus.z, 1);
    tick();

    // counter saturation with a 1-bit pattern, then clear beating a match
    drive(0, 0, 0, 1, 8'b0000_0001, 4'd1, 0, 1); tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 0, 0, 0, 0, 0);
      chk("len1_z", bus.z, 1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_cnt2", bus2.match_cnt, 3);
    chk("sat_cnt16", bus.match_cnt, 5);
    tick();
    drive(0, 1, 1, 0, 0, 0, 0, 1);
    chk("clr_match_z", bus.z, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("clr_cnt16", bus.match_cnt, 0);
    chk("clr_cnt2", bus2.match_cnt, 0);
    tick();

    // random stream against the model
    for (int i = 0; i < 3000; i++) begin
      bit         r, en, x, ld, ovl, clr;
      logic [7:0] pat;
      logic [3:0] len;
      r   = ($urandom_range(0, 199) == 0);
      ld  = ($urandom_range(0, 39) == 0);
      en  = ($urandom_range(0, 3) != 0);
      x   = 1'($urandom);
      clr = ($urandom_range(0, 63) == 0);
      pat = 8'($urandom);
      len = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      ovl = 1'($urandom);
      drive(r, en, x, ld, pat, len, ovl, clr);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
